// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and width defaults for the store buffer
package store_buffer_pkg;

   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;
   localparam int SB_DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      LOAD,
      FLUSH,
      DONE
   } sb_state_t;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - circular store queue exposing every entry for parallel address compare
import store_buffer_pkg::*;

module store_buffer_fifo #(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic [AW-1:0]            push_addr,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   input  logic                     upd_en,
   input  logic [$clog2(DEPTH)-1:0] upd_idx,
   input  logic [DW-1:0]            upd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH)-1:0] head,
   output logic [AW-1:0]            head_addr,
   output logic [DW-1:0]            head_data,
   output logic [AW-1:0]            entry_addr [DEPTH],
   output logic [DW-1:0]            entry_data [DEPTH],
   output logic [DEPTH-1:0]         valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] tail;
   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] off;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries marked valid are ever observed.
   always_ff @(posedge CLK) begin
      if (push) begin
         addr_q[tail] <= push_addr;
         data_q[tail] <= push_data;
      end
      if (upd_en) data_q[upd_idx] <= upd_data;
   end

   always_comb begin
      off   = '0;
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off      = PW'(i) - head;
         valid[i] = ({1'b0, off} < count);
      end
   end

   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);
   assign head_addr  = addr_q[head];
   assign head_data  = data_q[head];
   assign entry_addr = addr_q;
   assign entry_data = data_q;

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write buffer between datapath and dcache; STORE_BUFFER_COALESCE_EN merges same-word stores
import store_buffer_pkg::*;

module store_buffer #(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          dp_ren,
   input  logic          dp_wen,
   input  logic [AW-1:0] dp_addr,
   input  logic [DW-1:0] dp_store,
   output logic [DW-1:0] dp_load,
   output logic          dp_hit,
   input  logic          halt_in,
   output logic          flushed,
   output logic          dmemREN,
   output logic          dmemWEN,
   output logic [AW-1:0] dmemaddr,
   output logic [DW-1:0] dmemstore,
   input  logic [DW-1:0] dmemload,
   input  logic          dhit
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sb_state_t state, next_state;

   logic          push, pop, upd_en, full, empty;
   logic [CW-1:0] count;
   logic [PW-1:0] head, idx, fwd_idx, co_idx;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic [AW-1:0] entry_addr [DEPTH];
   logic [DW-1:0] entry_data [DEPTH];
   logic [DEPTH-1:0] valid;
   logic          fwd_hit, co_hit, wr_busy, st_ok, ld_window, load_miss;

   store_buffer_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
      .CLK        (CLK),
      .RST        (RST),
      .push       (push),
      .push_addr  (dp_addr),
      .push_data  (dp_store),
      .pop        (pop),
      .upd_en     (upd_en),
      .upd_idx    (co_idx),
      .upd_data   (dp_store),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .head       (head),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .entry_addr (entry_addr),
      .entry_data (entry_data),
      .valid      (valid)
   );

   // A cache write is in flight whenever a draining state has a head entry.
   assign wr_busy   = ((state == DRAIN) || (state == FLUSH)) && !empty;
   assign pop       = wr_busy && dhit;
   assign st_ok     = !halt_in && (state != FLUSH) && (state != DONE);
   assign ld_window = !halt_in && ((state == IDLE) || (state == DRAIN));
   assign load_miss = dp_ren && !fwd_hit && ld_window;
   assign flushed   = (state == DONE);

   // Walk entries oldest to youngest so the last match seen is the youngest.
   always_comb begin
      fwd_hit = 1'b0;
      fwd_idx = '0;
      co_hit  = 1'b0;
      co_idx  = '0;
      idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (valid[idx] && (entry_addr[idx][AW-1:2] == dp_addr[AW-1:2])) begin
            fwd_hit = 1'b1;
            fwd_idx = idx;
`ifdef STORE_BUFFER_COALESCE_EN
            if (!(wr_busy && (idx == head))) begin
               co_hit = 1'b1;
               co_idx = idx;
            end
`endif
         end
      end
   end

   always_comb begin
      push    = 1'b0;
      upd_en  = 1'b0;
      dp_hit  = 1'b0;
      dp_load = '0;
      if (dp_wen && st_ok) begin
         if (co_hit) begin
            upd_en = 1'b1;
            dp_hit = 1'b1;
         end else if (!full || pop) begin
            push   = 1'b1;
            dp_hit = 1'b1;
         end
      end else if (dp_ren && ld_window && fwd_hit) begin
         dp_hit  = 1'b1;
         dp_load = entry_data[fwd_idx];
      end else if (dp_ren && (state == LOAD) && dhit) begin
         dp_hit  = 1'b1;
         dp_load = dmemload;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      dmemaddr   = '0;
      dmemstore  = '0;
      if (wr_busy) begin
         dmemWEN   = 1'b1;
         dmemaddr  = head_addr;
         dmemstore = head_data;
      end
      case (state)
         IDLE: begin
            if (halt_in)        next_state = FLUSH;
            else if (load_miss) next_state = LOAD;
            else if (!empty)    next_state = DRAIN;
         end
         DRAIN: begin
            // FLUSH keeps presenting the same head, so a halt never drops the write.
            if (empty)          next_state = halt_in ? FLUSH : IDLE;
            else if (halt_in)   next_state = FLUSH;
            else if (dhit) begin
               if (load_miss)                        next_state = LOAD;
               else if ((count > CW'(1)) || push)    next_state = DRAIN;
               else                                  next_state = IDLE;
            end
         end
         LOAD: begin
            dmemREN  = 1'b1;
            dmemaddr = dp_addr;
            if (dhit) next_state = halt_in ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (empty || (dhit && (count == CW'(1)))) next_state = DONE;
         end
         DONE:    next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed vector bench for store_buffer
module tb_store_buffer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        dp_ren = 1'b0, dp_wen = 1'b0, halt_in = 1'b0, dhit = 1'b0;
   logic [31:0] dp_addr = '0, dp_store = '0, dmemload = '0;
   logic [31:0] dp_load, dmemaddr, dmemstore;
   logic        dp_hit, flushed, dmemREN, dmemWEN;

   int n_vec = 0;
   int n_err = 0;

   store_buffer dut (
      .CLK       (CLK),
      .RST       (RST),
      .dp_ren    (dp_ren),
      .dp_wen    (dp_wen),
      .dp_addr   (dp_addr),
      .dp_store  (dp_store),
      .dp_load   (dp_load),
      .dp_hit    (dp_hit),
      .halt_in   (halt_in),
      .flushed   (flushed),
      .dmemREN   (dmemREN),
      .dmemWEN   (dmemWEN),
      .dmemaddr  (dmemaddr),
      .dmemstore (dmemstore),
      .dmemload  (dmemload),
      .dhit      (dhit)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        ren, wen;
      logic [31:0] addr, store;
      logic        dhit;
      logic [31:0] mload;
      logic        e_hit;
      logic [31:0] e_load;
      logic        e_ren, e_wen;
      logic [31:0] e_daddr, e_dstore;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t mk(input logic ren, wen, input logic [31:0] addr, store,
                               input logic dh, input logic [31:0] mload,
                               input logic e_hit, input logic [31:0] e_load,
                               input logic e_ren, e_wen, input logic [31:0] e_daddr, e_dstore);
      vec_t v;
      v.ren = ren; v.wen = wen; v.addr = addr; v.store = store; v.dhit = dh; v.mload = mload;
      v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_wen = e_wen;
      v.e_daddr = e_daddr; v.e_dstore = e_dstore;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_hit, input logic [31:0] e_load,
                            input logic e_ren, e_wen, input logic [31:0] e_daddr, e_dstore,
                            input logic e_fl);
      chk({tag, ".dp_hit"},    32'(dp_hit),  32'(e_hit));
      chk({tag, ".dp_load"},   dp_load,      e_load);
      chk({tag, ".dmemREN"},   32'(dmemREN), 32'(e_ren));
      chk({tag, ".dmemWEN"},   32'(dmemWEN), 32'(e_wen));
      chk({tag, ".dmemaddr"},  dmemaddr,     e_daddr);
      chk({tag, ".dmemstore"}, dmemstore,    e_dstore);
      chk({tag, ".flushed"},   32'(flushed), 32'(e_fl));
   endtask

   task automatic cyc(input string tag, input logic ren, wen, input logic [31:0] addr, store,
                      input logic halt, dh, input logic [31:0] mload,
                      input logic e_hit, input logic [31:0] e_load, input logic e_ren, e_wen,
                      input logic [31:0] e_daddr, e_dstore, input logic e_fl);
      @(negedge CLK);
      dp_ren = ren; dp_wen = wen; dp_addr = addr; dp_store = store;
      halt_in = halt; dhit = dh; dmemload = mload;
      #4;
      check_all(tag, e_hit, e_load, e_ren, e_wen, e_daddr, e_dstore, e_fl);
   endtask

   task automatic idle_in();
      dp_ren = 0; dp_wen = 0; dp_addr = '0; dp_store = '0; halt_in = 0; dhit = 0; dmemload = '0;
   endtask

   logic [31:0] wa [$];
   logic [31:0] wd [$];
   logic [31:0] exp_a [3];
   logic [31:0] exp_d [3];
   logic        done;

   initial begin
      //            ren wen addr      store      dh mload      hit load       REN WEN daddr     dstore
      tbl[0]  = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[1]  = mk(0, 1, 32'h100,  32'hDEAD,  0, 32'h0,     1, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[2]  = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[3]  = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 1, 32'h100,  32'hDEAD);
      tbl[4]  = mk(0, 0, 32'h0,    32'h0,     1, 32'h0,     0, 32'h0,     0, 1, 32'h100,  32'hDEAD);
      tbl[5]  = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[6]  = mk(0, 1, 32'h20,   32'h1,     0, 32'h0,     1, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[7]  = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[8]  = mk(0, 1, 32'h20,   32'h2,     0, 32'h0,     1, 32'h0,     0, 1, 32'h20,   32'h1);
      tbl[9]  = mk(1, 0, 32'h20,   32'h0,     0, 32'h0,     1, 32'h2,     0, 1, 32'h20,   32'h1);
      tbl[10] = mk(0, 0, 32'h0,    32'h0,     1, 32'h0,     0, 32'h0,     0, 1, 32'h20,   32'h1);
      tbl[11] = mk(0, 0, 32'h0,    32'h0,     1, 32'h0,     0, 32'h0,     0, 1, 32'h20,   32'h2);
      tbl[12] = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[13] = mk(0, 1, 32'h30,   32'h5,     0, 32'h0,     1, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[14] = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[15] = mk(1, 0, 32'h40,   32'h0,     0, 32'h0,     0, 32'h0,     0, 1, 32'h30,   32'h5);
      tbl[16] = mk(1, 0, 32'h40,   32'h0,     1, 32'h0,     0, 32'h0,     0, 1, 32'h30,   32'h5);
      tbl[17] = mk(1, 0, 32'h40,   32'h0,     0, 32'h0,     0, 32'h0,     1, 0, 32'h40,   32'h0);
      tbl[18] = mk(1, 0, 32'h40,   32'h0,     1, 32'hBEEF,  1, 32'hBEEF,  1, 0, 32'h40,   32'h0);
      tbl[19] = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[20] = mk(1, 0, 32'h44,   32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);
      tbl[21] = mk(1, 0, 32'h44,   32'h0,     1, 32'h1234,  1, 32'h1234,  1, 0, 32'h44,   32'h0);
      tbl[22] = mk(0, 0, 32'h0,    32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,    32'h0);

      // Power-on reset state
      idle_in();
      @(negedge CLK);
      @(negedge CLK);
      #1;
      check_all("por", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      RST = 1'b0;

      for (int i = 0; i < 23; i++)
         cyc($sformatf("v%0d", i), tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store, 1'b0,
             tbl[i].dhit, tbl[i].mload, tbl[i].e_hit, tbl[i].e_load, tbl[i].e_ren,
             tbl[i].e_wen, tbl[i].e_daddr, tbl[i].e_dstore, 1'b0);

      // Full stall: fifth store waits for the first pop, then lands in the same cycle
      cyc("fs1", 0, 1, 32'h0,  32'h11, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
      cyc("fs2", 0, 1, 32'h4,  32'h22, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
      cyc("fs3", 0, 1, 32'h8,  32'h33, 0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h11, 0);
      cyc("fs4", 0, 1, 32'hC,  32'h44, 0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h11, 0);
      cyc("fs5", 0, 1, 32'h10, 32'h55, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h11, 0);
      cyc("fs6", 0, 1, 32'h10, 32'h55, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h11, 0);
      cyc("fs7", 0, 1, 32'h10, 32'h55, 0, 1, 0, 1, 0, 0, 1, 32'h0, 32'h11, 0);
      cyc("fs8", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h4, 32'h22, 0);
      cyc("fs9", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h8, 32'h33, 0);
      cyc("fsA", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'hC, 32'h44, 0);
      cyc("fsB", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h10, 32'h55, 0);
      cyc("fsC", 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);

`ifdef STORE_BUFFER_COALESCE_EN
      cyc("co1", 0, 1, 32'h60, 32'h1,  0, 0, 0, 1, 0, 0, 0, 32'h0,  32'h0, 0);
      cyc("co2", 0, 1, 32'h64, 32'h2,  0, 0, 0, 1, 0, 0, 0, 32'h0,  32'h0, 0);
      cyc("co3", 0, 1, 32'h68, 32'h3,  0, 0, 0, 1, 0, 0, 1, 32'h60, 32'h1, 0);
      cyc("co4", 0, 1, 32'h6C, 32'h4,  0, 0, 0, 1, 0, 0, 1, 32'h60, 32'h1, 0);
      cyc("co5", 0, 1, 32'h68, 32'h33, 0, 0, 0, 1, 0, 0, 1, 32'h60, 32'h1, 0);
      cyc("co6", 0, 1, 32'h60, 32'h99, 0, 0, 0, 0, 0, 0, 1, 32'h60, 32'h1, 0);
      cyc("co7", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h60, 32'h1, 0);
      cyc("co8", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h64, 32'h2, 0);
      cyc("co9", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h68, 32'h33, 0);
      cyc("coA", 0, 0, 32'h0,  32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h6C, 32'h4, 0);
      cyc("coB", 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0, 0);
`endif

      // Reset while draining discards buffered stores
      cyc("rs1", 0, 1, 32'h70, 32'h7, 0, 0, 0, 1, 0, 0, 0, 32'h0,  32'h0, 0);
      cyc("rs2", 0, 1, 32'h74, 32'h8, 0, 0, 0, 1, 0, 0, 0, 32'h0,  32'h0, 0);
      cyc("rs3", 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h70, 32'h7, 0);
      @(negedge CLK);
      idle_in();
      RST = 1'b1;
      #1;
      check_all("rs_mid", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      @(negedge CLK);
      RST = 1'b0;
      cyc("rs4", 0, 1, 32'h100, 32'hDEAD, 0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h0,    0);
      cyc("rs5", 0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,    0);
      cyc("rs6", 0, 0, 32'h0,   32'h0,    0, 1, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD, 0);
      cyc("rs7", 0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,    0);

      // Halt flush: three writes in FIFO order, then sticky flushed
      cyc("hf1", 0, 1, 32'h50, 32'hA, 0, 0, 0, 1, 0, 0, 0, 32'h0,  32'h0, 0);
      cyc("hf2", 0, 1, 32'h54, 32'hB, 0, 0, 0, 1, 0, 0, 0, 32'h0,  32'h0, 0);
      cyc("hf3", 0, 1, 32'h58, 32'hC, 0, 0, 0, 1, 0, 0, 1, 32'h50, 32'hA, 0);
      cyc("hf4", 0, 0, 32'h0,  32'h0, 1, 0, 0, 0, 0, 0, 1, 32'h50, 32'hA, 0);
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         idle_in();
         halt_in = 1'b1;
         dhit    = 1'b1;
         #4;
         if (flushed) begin
            done = 1'b1;
            break;
         end
         if (dmemWEN) begin
            wa.push_back(dmemaddr);
            wd.push_back(dmemstore);
         end
      end
      chk("flush_reached", 32'(done), 32'h1);
      chk("flush_writes", 32'(wa.size()), 32'd3);
      exp_a = '{32'h50, 32'h54, 32'h58};
      exp_d = '{32'hA, 32'hB, 32'hC};
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("flush_addr%0d", k), (k < wa.size()) ? wa[k] : 32'hFFFF_FFFF, exp_a[k]);
         chk($sformatf("flush_data%0d", k), (k < wd.size()) ? wd[k] : 32'hFFFF_FFFF, exp_d[k]);
      end
      cyc("hd1", 0, 1, 32'h80, 32'h9, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
      cyc("hd2", 0, 1, 32'h80, 32'h9, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
      cyc("hd3", 1, 0, 32'h84, 32'h0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
